uart_tx_frame_serializer: RTL and testbench



---
 rtl/uart_tx_frame_serializer.sv | 137 +++++++++++++
 tb/tb_uart_tx_frame_serializer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_serializer.sv
// rtl/uart_tx_frame_serializer.sv - parametrised UART TX frame serializer clocked by the baud tick
module uart_tx_frame_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int LSB_FIRST  = 1
) (
    input  logic                  baud_rate_tx,
    input  logic                  rst,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [DATA_WIDTH-1:0] p_data_in,
    output logic                  s_data_out,
    output logic                  tx_busy,
    output logic                  frame_done
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic [CW-1:0]           bit_cnt;
    logic                    stop_cnt;
    logic                    parity_bit;

    logic                    final_stop;
    logic                    accept;
    logic                    head_bit;
    logic [DATA_WIDTH-1:0]   shift_next;

    // Parity over the whole word; odd parity is the even result inverted.
    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d);
        return (^d) ^ (PARITY_ODD != 0);
    endfunction

    // The final stop cycle doubles as the accept window so frames can abut.
    assign final_stop = (state == STOP) && (stop_cnt == LAST_STOP);
    assign tx_ready   = (state == IDLE) || final_stop;
    assign accept     = tx_valid && tx_ready;

    // The next bit to send always sits at the head of the shift register;
    // the register moves toward that head once per data bit.
    assign head_bit   = (LSB_FIRST != 0) ? shift_reg[0] : shift_reg[DATA_WIDTH-1];
    assign shift_next = (LSB_FIRST != 0) ? {1'b0, shift_reg[DATA_WIDTH-1:1]}
                                         : {shift_reg[DATA_WIDTH-2:0], 1'b0};

    // Frame FSM; every output is registered with the value for the state being entered.
    always_ff @(posedge baud_rate_tx or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            parity_bit <= 1'b0;
            s_data_out <= 1'b1;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (accept) begin
                // Accept is only possible in IDLE or the final stop cycle.
                state      <= START;
                shift_reg  <= p_data_in;
                parity_bit <= calc_parity(p_data_in);
                bit_cnt    <= '0;
                stop_cnt   <= 1'b0;
                s_data_out <= 1'b0;
                tx_busy    <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        s_data_out <= 1'b1;
                        tx_busy    <= 1'b0;
                    end
                    START: begin
                        state      <= DATA;
                        s_data_out <= head_bit;
                        shift_reg  <= shift_next;
                        bit_cnt    <= '0;
                    end
                    DATA: begin
                        if (bit_cnt == LAST_BIT) begin
                            if (PARITY_EN != 0) begin
                                state      <= PARITY;
                                s_data_out <= parity_bit;
                            end else begin
                                state      <= STOP;
                                s_data_out <= 1'b1;
                                stop_cnt   <= 1'b0;
                                frame_done <= (STOP_BITS == 1);
                            end
                        end else begin
                            bit_cnt    <= bit_cnt + 1'b1;
                            s_data_out <= head_bit;
                            shift_reg  <= shift_next;
                        end
                    end
                    PARITY: begin
                        state      <= STOP;
                        s_data_out <= 1'b1;
                        stop_cnt   <= 1'b0;
                        frame_done <= (STOP_BITS == 1);
                    end
                    STOP: begin
                        s_data_out <= 1'b1;
                        if (final_stop) begin
                            state    <= IDLE;
                            tx_busy  <= 1'b0;
                            stop_cnt <= 1'b0;
                        end else begin
                            // Entering the last stop bit: that is the frame_done cycle.
                            stop_cnt   <= stop_cnt + 1'b1;
                            frame_done <= 1'b1;
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        s_data_out <= 1'b1;
                        tx_busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// tb/tb_uart_tx_frame_serializer.sv - directed vector bench for uart_tx_frame_serializer
module tb_uart_tx_frame_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [3:0]        valid;
    logic [3:0]        ready;
    logic [3:0]        line;
    logic [3:0]        busy;
    logic [3:0]        done;
    logic [3:0][15:0]  pdata;

    int total = 0;
    int bad   = 0;

    // 0: defaults, 1: odd parity, 2: MSB first / no parity / two stops, 3: 5-bit data
    uart_tx_frame_serializer u_def (
        .baud_rate_tx(clk), .rst(rst), .tx_valid(valid[0]), .tx_ready(ready[0]),
        .p_data_in(pdata[0][7:0]), .s_data_out(line[0]), .tx_busy(busy[0]), .frame_done(done[0]));

    uart_tx_frame_serializer #(.PARITY_ODD(1)) u_odd (
        .baud_rate_tx(clk), .rst(rst), .tx_valid(valid[1]), .tx_ready(ready[1]),
        .p_data_in(pdata[1][7:0]), .s_data_out(line[1]), .tx_busy(busy[1]), .frame_done(done[1]));

    uart_tx_frame_serializer #(.LSB_FIRST(0), .PARITY_EN(0), .STOP_BITS(2)) u_msb (
        .baud_rate_tx(clk), .rst(rst), .tx_valid(valid[2]), .tx_ready(ready[2]),
        .p_data_in(pdata[2][7:0]), .s_data_out(line[2]), .tx_busy(busy[2]), .frame_done(done[2]));

    uart_tx_frame_serializer #(.DATA_WIDTH(5)) u_w5 (
        .baud_rate_tx(clk), .rst(rst), .tx_valid(valid[3]), .tx_ready(ready[3]),
        .p_data_in(pdata[3][4:0]), .s_data_out(line[3]), .tx_busy(busy[3]), .frame_done(done[3]));

    typedef struct {
        int          cfg;
        logic [15:0] data;
        int          n;
        logic [31:0] exp;   // first bit on the line is the MSB of the n-bit field
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic send(input int c, input logic [15:0] d, input int n,
                        input logic [31:0] exp, input string name);
        logic [31:0] seq;
        int nb;
        int nd;
        seq = '0;
        nb  = 0;
        nd  = 0;
        check({name, "/ready_before"}, 32'(ready[c]), 32'd1);
        pdata[c] = d;
        valid[c] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid[c] = 1'b0;
        pdata[c] = ~d;
        for (int j = 0; j < n; j++) begin
            seq = {seq[30:0], line[c]};
            nb += int'(busy[c]);
            nd += int'(done[c]);
            if (j == n - 2) check({name, "/ready_prelast"}, 32'(ready[c]), 32'd0);
            if (j == n - 1) begin
                check({name, "/ready_last"}, 32'(ready[c]), 32'd1);
                check({name, "/done_last"}, 32'(done[c]), 32'd1);
            end
            @(negedge clk);
        end
        check({name, "/line_seq"}, seq, exp);
        check({name, "/busy_cycles"}, 32'(nb), 32'(n));
        check({name, "/done_count"}, 32'(nd), 32'd1);
        check({name, "/idle_line"}, 32'(line[c]), 32'd1);
        check({name, "/idle_busy"}, 32'(busy[c]), 32'd0);
        check({name, "/idle_done"}, 32'(done[c]), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] seq;
        int nd;
        int nb;

        vecs.push_back('{0, 16'h000F, 11, 32'b01111000001});
        vecs.push_back('{0, 16'h00A5, 11, 32'b01010010101});
        vecs.push_back('{0, 16'h003C, 11, 32'b00011110001});
        vecs.push_back('{0, 16'h0001, 11, 32'b01000000011});
        vecs.push_back('{0, 16'h00FF, 11, 32'b01111111101});
        vecs.push_back('{1, 16'h000F, 11, 32'b01111000011});
        vecs.push_back('{1, 16'h0000, 11, 32'b00000000011});
        vecs.push_back('{1, 16'h0080, 11, 32'b00000000101});
        vecs.push_back('{2, 16'h0080, 11, 32'b01000000011});
        vecs.push_back('{2, 16'h000F, 11, 32'b00000111111});
        vecs.push_back('{2, 16'h0053, 11, 32'b00101001111});
        vecs.push_back('{3, 16'h001F, 8,  32'b01111111});
        vecs.push_back('{3, 16'h0006, 8,  32'b00110001});
        vecs.push_back('{3, 16'h0010, 8,  32'b00000111});

        rst   = 1'b1;
        valid = '0;
        pdata = '0;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("reset%0d/line", c), 32'(line[c]), 32'd1);
            check($sformatf("reset%0d/ready", c), 32'(ready[c]), 32'd1);
            check($sformatf("reset%0d/busy", c), 32'(busy[c]), 32'd0);
            check($sformatf("reset%0d/done", c), 32'(done[c]), 32'd0);
        end

        // tx_valid during reset must not start a frame
        valid = 4'hF;
        pdata = {4{16'h0000}};
        @(posedge clk);
        @(negedge clk);
        check("valid_in_reset/busy", 32'(busy), 32'd0);
        check("valid_in_reset/line", 32'(line), 32'hF);
        valid = '0;
        rst   = 1'b0;
        @(negedge clk);
        check("after_release/busy", 32'(busy), 32'd0);
        check("after_release/line", 32'(line), 32'hF);

        foreach (vecs[i]) begin
            send(vecs[i].cfg, vecs[i].data, vecs[i].n, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Back-to-back frames with tx_valid held high
        seq = '0;
        nd  = 0;
        nb  = 0;
        pdata[0] = 16'h00A5;
        valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pdata[0] = 16'h003C;
        for (int j = 0; j < 22; j++) begin
            seq = {seq[30:0], line[0]};
            nd += int'(done[0]);
            nb += int'(busy[0]);
            if (j == 5)  check("b2b/ready_mid", 32'(ready[0]), 32'd0);
            if (j == 10) check("b2b/done_first", 32'(done[0]), 32'd1);
            if (j == 11) begin
                check("b2b/no_idle_start", 32'(line[0]), 32'd0);
                valid[0] = 1'b0;
            end
            @(negedge clk);
        end
        check("b2b/line_seq", seq, 32'b0101001010100011110001);
        check("b2b/done_count", 32'(nd), 32'd2);
        check("b2b/busy_cycles", 32'(nb), 32'd22);
        check("b2b/idle_line", 32'(line[0]), 32'd1);

        // Reset during the 4th data bit of 8'hFF
        pdata[0] = 16'h00FF;
        valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst/busy_before", 32'(busy[0]), 32'd1);
        rst      = 1'b1;
        valid[0] = 1'b1;
        #1;
        check("midrst/line", 32'(line[0]), 32'd1);
        check("midrst/ready", 32'(ready[0]), 32'd1);
        check("midrst/busy", 32'(busy[0]), 32'd0);
        check("midrst/done", 32'(done[0]), 32'd0);
        repeat (2) @(negedge clk);
        check("midrst/busy_held", 32'(busy[0]), 32'd0);
        valid[0] = 1'b0;
        rst      = 1'b0;
        nd = 0;
        nb = 0;
        seq = '0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            nd += int'(done[0]);
            nb += int'(busy[0]);
            seq = {seq[30:0], line[0]};
        end
        check("midrst/no_done", 32'(nd), 32'd0);
        check("midrst/no_resend_busy", 32'(nb), 32'd0);
        check("midrst/no_resend_line", seq, 32'h00000FFF);
        send(0, 16'h000F, 11, 32'b01111000001, "after_midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
